// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 4-digit seven-segment driver. Waits for each anode dwell to
// settle, decodes the segment pattern to a hex nibble and reassembles a 16-bit display frame.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:6]  seg,
  input  logic [3:0]  digit,
  output logic [15:0] value,
  output logic [3:0]  blank_mask,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        anode_err,
  output logic        frame_err
);

  typedef enum logic {SYNC, COLLECT} state_e;

  typedef struct packed {
    logic       ok;
    logic       blank;
    logic [3:0] nib;
  } dec_t;

  // Active-high segment pattern {g..a} -> nibble; all-off is a legal blank digit.
  function automatic dec_t decode(input logic [6:0] pat);
    dec_t r;
    r = '{ok: 1'b1, blank: 1'b0, nib: 4'h0};
    case (pat)
      7'h3F: r.nib = 4'h0;
      7'h06: r.nib = 4'h1;
      7'h5B: r.nib = 4'h2;
      7'h4F: r.nib = 4'h3;
      7'h66: r.nib = 4'h4;
      7'h6D: r.nib = 4'h5;
      7'h7D: r.nib = 4'h6;
      7'h07: r.nib = 4'h7;
      7'h7F: r.nib = 4'h8;
      7'h6F: r.nib = 4'h9;
      7'h77: r.nib = 4'hA;
      7'h7C: r.nib = 4'hB;
      7'h39: r.nib = 4'hC;
      7'h5E: r.nib = 4'hD;
      7'h79: r.nib = 4'hE;
      7'h71: r.nib = 4'hF;
      7'h00: r.blank = 1'b1;
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

  // Sampled copy keeps seg bit k at index k (a = bit 0).
  logic [6:0]       s_seg_q, p_seg_q;
  logic [3:0]       s_dig_q, p_dig_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             same, accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_q <= '1;
      p_seg_q <= '1;
      s_dig_q <= '1;
      p_dig_q <= '1;
      cnt_q   <= '0;
    end else begin
      s_seg_q <= {seg[6], seg[5], seg[4], seg[3], seg[2], seg[1], seg[0]};
      s_dig_q <= digit;
      p_seg_q <= s_seg_q;
      p_dig_q <= s_dig_q;
      cnt_q   <= cnt_d;
    end
  end

  assign same   = (s_seg_q == p_seg_q) && (s_dig_q == p_dig_q);
  // Saturation keeps a held dwell from wrapping back onto the accept count.
  assign cnt_d  = !same ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
  assign accept = same && (cnt_q == CNT_W'(STABLE_CYCLES - 1));

  dec_t       dec;
  logic       one_low;
  logic [1:0] idx;
  logic [3:0] hit, seen_nx;

  always_comb begin
    dec     = decode(~s_seg_q);
    one_low = $onehot(~s_dig_q);
    idx     = 2'd0;
    case (~s_dig_q)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  state_e          state_q;
  logic [3:0]      seen_q;
  logic [3:0][3:0] slot_q, frame_v;
  logic [3:0]      sblank_q, frame_b;
  logic [15:0]     value_q;
  logic [3:0]      blank_q;
  logic            fv_q, se_q, ae_q, fe_q;

  assign hit     = 4'b0001 << idx;
  assign seen_nx = seen_q | hit;

  // Completed frame including the nibble being written this cycle.
  always_comb begin
    frame_v      = slot_q;
    frame_b      = sblank_q;
    frame_v[idx] = dec.nib;
    frame_b[idx] = dec.blank;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SYNC;
      seen_q   <= '0;
      slot_q   <= '0;
      sblank_q <= '0;
      value_q  <= '0;
      blank_q  <= '0;
      fv_q     <= 1'b0;
      se_q     <= 1'b0;
      ae_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      se_q <= 1'b0;
      ae_q <= 1'b0;
      fe_q <= 1'b0;
      if (accept && (s_dig_q != 4'hF)) begin
        if (!one_low) begin
          ae_q <= 1'b1;
        end else if (!dec.ok) begin
          se_q <= 1'b1;
        end else begin
          case (state_q)
            SYNC: begin
              if (idx == 2'd0) begin
                slot_q[0]   <= dec.nib;
                sblank_q[0] <= dec.blank;
                seen_q      <= 4'b0001;
                state_q     <= COLLECT;
              end
            end
            COLLECT: begin
              if (seen_q[idx]) begin
                fe_q <= 1'b1;
                if (idx == 2'd0) begin
                  // A repeated digit 0 is taken as the start of a fresh frame.
                  slot_q[0]   <= dec.nib;
                  sblank_q[0] <= dec.blank;
                  seen_q      <= 4'b0001;
                end else begin
                  seen_q  <= '0;
                  state_q <= SYNC;
                end
              end else begin
                slot_q[idx]   <= dec.nib;
                sblank_q[idx] <= dec.blank;
                if (&seen_nx) begin
                  value_q <= frame_v;
                  blank_q <= frame_b;
                  fv_q    <= 1'b1;
                  seen_q  <= '0;
                  state_q <= SYNC;
                end else begin
                  seen_q <= seen_nx;
                end
              end
            end
            default: state_q <= SYNC;
          endcase
        end
      end
    end
  end

  assign value       = value_q;
  assign blank_mask  = blank_q;
  assign frame_valid = fv_q;
  assign seg_err     = se_q;
  assign anode_err   = ae_q;
  assign frame_err   = fe_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench: each dwell pushes its expected pulse (kind, cycle, frame) to a scoreboard
// that a negedge monitor pops whenever the decoder raises any pulse.
module tb_seg_scan_decoder;
  localparam int SC = 4;
  localparam logic [3:0] K_FV = 4'b1000, K_SE = 4'b0100, K_AE = 4'b0010, K_FE = 4'b0001;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst;
  logic [0:6]  seg;
  logic [3:0]  digit;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic        frame_valid, seg_err, anode_err, frame_err;

  seg_scan_decoder #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .seg(seg), .digit(digit), .value(value), .blank_mask(blank_mask),
    .frame_valid(frame_valid), .seg_err(seg_err), .anode_err(anode_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  kind;
    int          cyc;
    logic [15:0] val;
    logic [3:0]  blk;
  } ev_t;
  ev_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one pattern for n cycles; an expected pulse lands SC+1 edges after first sample.
  task automatic drive(input logic [3:0] dg, input logic [6:0] pat, input int n,
                       input logic [3:0] kind, input logic [15:0] v, input logic [3:0] b);
    ev_t e;
    digit = dg;
    for (int k = 0; k < 7; k++) seg[k] = ~pat[k];
    if (kind != 4'h0) begin
      e = '{kind, cyc + SC + 2, v, b};
      sb.push_back(e);
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dw(input int i, input logic [6:0] pat, input int n = 8,
                    input logic [3:0] kind = 4'h0, input logic [15:0] v = 16'h0,
                    input logic [3:0] b = 4'h0);
    logic [3:0] one;
    one = 4'b0001;
    drive(~(one << i), pat, n, kind, v, b);
    drive(4'hF, 7'h00, 2, 4'h0, 16'h0, 4'h0);
  endtask

  always @(negedge clk) begin
    logic [3:0] k;
    ev_t e;
    k = {frame_valid, seg_err, anode_err, frame_err};
    if (k != 4'h0) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {28'h0, k}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {28'h0, k}, {28'h0, e.kind});
        chk("pulse_cycle", cyc, e.cyc);
        if (e.kind == K_FV) begin
          chk("frame_value", {16'h0, value}, {16'h0, e.val});
          chk("frame_blank", {28'h0, blank_mask}, {28'h0, e.blk});
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    digit = 4'hF;
    seg   = '1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_value", {16'h0, value}, 32'h0);
    chk("reset_blank", {28'h0, blank_mask}, 32'h0);
    chk("reset_pulses", {28'h0, frame_valid, seg_err, anode_err, frame_err}, 32'h0);

    // Dwells too short to settle: nothing accepted.
    dw(0, HEX[1], 3); dw(1, HEX[2], 3); dw(2, HEX[3], 3); dw(3, HEX[4], 3);
    repeat (10) @(posedge clk);
    #1;
    chk("short_dwell_value", {16'h0, value}, 32'h0);

    // Clean scan.
    dw(0, HEX[1]); dw(1, HEX[2]); dw(2, HEX[3]); dw(3, HEX[4], 8, K_FV, 16'h4321, 4'h0);
    chk("scan_4321", {16'h0, value}, 32'h4321);

    // Non-hex digit 2, then a clean scan that restarts on digit 0.
    dw(0, HEX[1]); dw(1, HEX[2]); dw(2, 7'h49, 8, K_SE); dw(3, HEX[4]);
    dw(0, HEX[11], 8, K_FE); dw(1, HEX[10]); dw(2, HEX[9]);
    dw(3, HEX[8], 8, K_FV, 16'h89AB, 4'h0);
    chk("scan_89ab", {16'h0, value}, 32'h89AB);

    // Two anodes low mid-frame: error only, frame collection continues.
    dw(0, HEX[12]);
    drive(4'b0101, HEX[3], 8, K_AE, 16'h0, 4'h0);
    drive(4'hF, 7'h00, 2, 4'h0, 16'h0, 4'h0);
    dw(1, HEX[13]); dw(2, HEX[14]); dw(3, HEX[15], 8, K_FV, 16'hFEDC, 4'h0);

    // Repeated digit 1 aborts; digit 2 in SYNC is ignored; next full scan succeeds.
    dw(0, HEX[0]); dw(1, HEX[15]); dw(1, HEX[15], 8, K_FE);
    dw(2, HEX[7]);
    dw(0, HEX[0]); dw(1, HEX[15]); dw(2, HEX[0]); dw(3, HEX[10], 8, K_FV, 16'hA0F0, 4'h0);
    chk("scan_a0f0", {16'h0, value}, 32'hA0F0);

    // Blank digit 3; digit 0 held well past counter saturation must fire once.
    dw(0, HEX[2], 300); dw(1, HEX[1]); dw(2, HEX[0]);
    dw(3, 7'h00, 8, K_FV, 16'h0012, 4'b1000);
    chk("blank_value", {16'h0, value}, 32'h0012);
    chk("blank_mask", {28'h0, blank_mask}, 32'h8);

    // Reset mid-frame discards partial slots.
    dw(0, HEX[5]); dw(1, HEX[6]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_value", {16'h0, value}, 32'h0);
    chk("midrst_blank", {28'h0, blank_mask}, 32'h0);
    dw(2, HEX[7]); dw(3, HEX[8]);
    dw(0, HEX[4]); dw(1, HEX[3]); dw(2, HEX[2]); dw(3, HEX[1], 8, K_FV, 16'h1234, 4'h0);
    chk("post_rst_value", {16'h0, value}, 32'h1234);

    repeat (12) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
